// File: rtl/fpga_config_loader.sv
// Configuration writer for the fabric: receives a byte-serial bitstream over a
// valid/ready link, checks framing and checksum, and drives a write bus that
// loads the tile and switch-box configuration registers.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   in_data/in_valid bitstream byte and its valid flag
//   in_ready         byte accepted this cycle when in_valid & in_ready
//   clear            leaves DONE/ERROR and returns to HUNT
//   cfg_we           one-cycle write strobe to target cfg_addr
//   cfg_addr         target index
//   cfg_data         frame payload, first received byte in [7:0]
//   cfg_enable       fabric configuration valid (checksum passed)
//   done / error     stream accepted / rejected
//   frames_written   saturating count of cfg_we pulses since last HUNT entry
module fpga_config_loader #(
  parameter int unsigned FRAME_BYTES = 5,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned NUM_TARGETS = 36,
  parameter logic [7:0]  SYNC        = 8'hA5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic                     cfg_we,
  output logic [ADDR_W-1:0]        cfg_addr,
  output logic [8*FRAME_BYTES-1:0] cfg_data,
  output logic                     cfg_enable,
  output logic                     done,
  output logic                     error,
  output logic [7:0]               frames_written
);

  localparam int unsigned DATA_W = 8 * FRAME_BYTES;
  localparam int unsigned IDX_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  typedef enum logic [2:0] {
    S_HUNT,
    S_COUNT,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state, next_state;
  logic [7:0]         sum_q;
  logic [7:0]         frames_left;
  logic [ADDR_W-1:0]  addr_q;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  frame_q;

  logic               accept_c;
  logic [7:0]         sum_c;
  logic [DATA_W-1:0]  frame_c;

  // Byte transfer and running checksum including the current byte
  always_comb begin
    accept_c = in_valid & in_ready;
    sum_c    = sum_q + in_data;
  end

  // Partial frame with the current byte merged into its slot
  always_comb begin
    frame_c = frame_q;
    frame_c[int'(idx)*8 +: 8] = in_data;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_HUNT;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_HUNT:  if (accept_c && in_data == SYNC) next_state = S_COUNT;
      S_COUNT: if (accept_c) next_state = (in_data == 8'd0) ? S_CHECK : S_ADDR;
      S_ADDR:  if (accept_c) next_state = (32'(in_data) >= NUM_TARGETS) ? S_ERROR : S_DATA;
      S_DATA:  if (accept_c && idx == IDX_W'(FRAME_BYTES - 1)) next_state = S_WRITE;
      S_WRITE: next_state = (frames_left == 8'd1) ? S_CHECK : S_ADDR;
      S_CHECK: if (accept_c) next_state = (sum_c == 8'd0) ? S_DONE : S_ERROR;
      S_DONE:  if (clear) next_state = S_HUNT;
      S_ERROR: if (clear) next_state = S_HUNT;
      default: next_state = S_HUNT;
    endcase
  end

  // Registered outputs follow next_state so they line up with the state they describe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b1;
      cfg_we     <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cfg_enable <= 1'b0;
    end else begin
      in_ready   <= (next_state == S_HUNT)  || (next_state == S_COUNT) ||
                    (next_state == S_ADDR)  || (next_state == S_DATA)  ||
                    (next_state == S_CHECK);
      cfg_we     <= (next_state == S_WRITE);
      done       <= (next_state == S_DONE);
      error      <= (next_state == S_ERROR);
      cfg_enable <= (next_state == S_DONE);
    end
  end

  // Datapath: checksum, frame counter, address/payload capture, write bus
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q          <= 8'd0;
      frames_left    <= 8'd0;
      addr_q         <= '0;
      idx            <= '0;
      frame_q        <= '0;
      cfg_addr       <= '0;
      cfg_data       <= '0;
      frames_written <= 8'd0;
    end else begin
      if (next_state == S_HUNT) begin
        sum_q <= 8'd0;
      end else if (accept_c && (state == S_COUNT || state == S_ADDR ||
                                state == S_DATA  || state == S_CHECK)) begin
        sum_q <= sum_c;
      end

      if (accept_c && state == S_COUNT) frames_left <= in_data;
      else if (state == S_WRITE)        frames_left <= frames_left - 8'd1;

      if (accept_c && state == S_ADDR) begin
        addr_q <= ADDR_W'(in_data);
        idx    <= '0;
      end

      if (accept_c && state == S_DATA) begin
        frame_q <= frame_c;
        idx     <= idx + IDX_W'(1);
      end

      // Bus is loaded together with the strobe and then held until the next write
      if (state == S_DATA && next_state == S_WRITE) begin
        cfg_addr <= addr_q;
        cfg_data <= frame_c;
      end

      if (next_state == S_HUNT) begin
        frames_written <= 8'd0;
      end else if (state == S_DATA && next_state == S_WRITE &&
                   frames_written != 8'hFF) begin
        frames_written <= frames_written + 8'd1;
      end
    end
  end

endmodule
